// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_stage
//  Description : Fetch PC register plus IF/ID pipeline register with stall,
//                flush and redirect control, and an immediate-format /
//                illegal-opcode decode of the registered instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [2:0]  SrcExt,
    output logic [31:7] Imm,
    output logic        IllegalD
);

    // Bubble contents: canonical NOP (addi x0, x0, 0)
    localparam logic [31:0] c_NOP       = 32'h0000_0013;

    // Opcodes recognised by the decoder
    localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_REG    = 7'b0110011;

    // Immediate-format select encodings
    localparam logic [2:0]  c_EXT_NONE  = 3'b000;
    localparam logic [2:0]  c_EXT_I     = 3'b001;
    localparam logic [2:0]  c_EXT_S     = 3'b010;
    localparam logic [2:0]  c_EXT_B     = 3'b011;
    localparam logic [2:0]  c_EXT_U     = 3'b100;
    localparam logic [2:0]  c_EXT_J     = 3'b101;
    localparam logic [2:0]  c_EXT_SHAMT = 3'b110;

    logic [31:0] r_pcf;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;
    logic [31:0] w_pcf_plus4;
    logic [2:0]  w_src_ext;
    logic        w_illegal;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;

    assign w_pcf_plus4 = r_pcf + 32'd4;
    assign w_opcode    = r_instr_d[6:0];
    assign w_funct3    = r_instr_d[14:12];

    // Fetch PC: reset, then redirect (beats stall), then hold, then advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcf <= RESET_PC;
        end else if (PCSrc) begin
            r_pcf <= PCTarget;
        end else if (!StallF) begin
            r_pcf <= w_pcf_plus4;
        end
    end

    // Decode register: reset/flush insert a bubble, stall holds, else capture
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            r_instr_d    <= c_NOP;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (!StallD) begin
            r_instr_d    <= InstrF;
            r_pc_d       <= r_pcf;
            r_pc_plus4_d <= w_pcf_plus4;
            r_valid_d    <= 1'b1;
        end
    end

    // Immediate-format and legality decode; bubbles decode as nothing
    always_comb begin
        w_src_ext = c_EXT_NONE;
        w_illegal = 1'b0;
        if (r_valid_d) begin
            case (w_opcode)
                c_OP_IMM: begin
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        w_src_ext = c_EXT_SHAMT;
                    end else begin
                        w_src_ext = c_EXT_I;
                    end
                end
                c_OP_LOAD,
                c_OP_JALR:   w_src_ext = c_EXT_I;
                c_OP_STORE:  w_src_ext = c_EXT_S;
                c_OP_BRANCH: w_src_ext = c_EXT_B;
                c_OP_LUI,
                c_OP_AUIPC:  w_src_ext = c_EXT_U;
                c_OP_JAL:    w_src_ext = c_EXT_J;
                c_OP_REG:    w_src_ext = c_EXT_NONE;
                default: begin
                    w_src_ext = c_EXT_NONE;
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign PCF      = r_pcf;
    assign InstrD   = r_instr_d;
    assign PCD      = r_pc_d;
    assign PCPlus4D = r_pc_plus4_d;
    assign ValidD   = r_valid_d;
    assign SrcExt   = w_src_ext;
    assign IllegalD = w_illegal;
    assign Imm      = r_instr_d[31:7];

endmodule
`default_nettype wire
